// File: rtl/shift_add_multiplier_if.sv
// Handshake and data bundle between a requesting datapath, the multiplier and its consumer.
// Request side: valid_i/ready_i with a, b, signed_i. Response side: valid_o/ready_o with product.
// master = the environment driving operands and taking results; slave = the multiplier itself.
interface shift_add_multiplier_if #(
  parameter int N = 8
);
  logic           valid_i;
  logic           ready_i;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           signed_i;
  logic           valid_o;
  logic           ready_o;
  logic [2*N-1:0] product;

  modport master (
    output valid_i, a, b, signed_i, ready_o,
    input  ready_i, valid_o, product
  );

  modport slave (
    input  valid_i, a, b, signed_i, ready_o,
    output ready_i, valid_o, product
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier, unsigned or two's-complement chosen per transaction.
// Latency: N cycles from accept to valid_o for non-zero operands, 1 cycle when either operand is 0.
// Backpressure: result held in DONE while ready_o=0; ready_i is high only in IDLE.
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carries valid_i/ready_i,
//        a, b, signed_i on the request side and valid_o/ready_o, product on the response side.
module shift_add_multiplier #(
  parameter int N = 8
) (
  input logic                   clk,
  input logic                   rst,
  shift_add_multiplier_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    COMPUTING = 2'b01,
    DONE      = 2'b10
  } state_t;

  state_t         state_q,   state_d;
  logic [N-1:0]   mag_a_q,   mag_a_d;
  logic [N-1:0]   mplr_q,    mplr_d;
  logic [2*N:0]   acc_q,     acc_d;
  logic [CW-1:0]  cnt_q,     cnt_d;
  logic           neg_q,     neg_d;
  logic [2*N-1:0] product_q, product_d;

  logic           a_neg;
  logic           b_neg;
  logic [N-1:0]   abs_a;
  logic [N-1:0]   abs_b;
  logic           any_zero;
  logic [N:0]     sum;
  logic [2*N:0]   acc_step;
  logic [2*N-1:0] result;

  // Operand magnitudes; -2^(N-1) negates to itself, which read unsigned is the right magnitude.
  always_comb begin
    a_neg    = bus.signed_i & bus.a[N-1];
    b_neg    = bus.signed_i & bus.b[N-1];
    abs_a    = a_neg ? -bus.a : bus.a;
    abs_b    = b_neg ? -bus.b : bus.b;
    any_zero = (bus.a == '0) || (bus.b == '0);
  end

  // One multiply step: add into the upper N+1 bits, then shift the whole accumulator right.
  // The top accumulator bit is always 0 before the add, so the sum cannot overflow N+1 bits.
  always_comb begin
    sum      = acc_q[2*N:N] + (mplr_q[0] ? {1'b0, mag_a_q} : '0);
    acc_step = {sum, acc_q[N-1:0]} >> 1;
    result   = acc_step[2*N-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mag_a_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mag_a_q   <= mag_a_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mag_a_d   = mag_a_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          mag_a_d = abs_a;
          mplr_d  = abs_b;
          // Sign of the result; a zero operand never reaches the negate, so no -0 concern.
          neg_d   = bus.signed_i & (bus.a[N-1] ^ bus.b[N-1]);
          acc_d   = '0;
          cnt_d   = CW'(N);
          if (any_zero) begin
            product_d = '0;
            state_d   = DONE;
          end else begin
            state_d   = COMPUTING;
          end
        end
      end

      COMPUTING: begin
        acc_d  = acc_step;
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          product_d = neg_q ? -result : result;
          state_d   = DONE;
        end
      end

      DONE: begin
        if (bus.ready_o) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready_i = (state_q == IDLE);
  assign bus.valid_o = (state_q == DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomised and directed bench for shift_add_multiplier with a queue-based scoreboard.
// Expected products come from plain signed/unsigned integer multiplication of the operands.
// A monitor pops one expectation per output handshake; the driver checks latency and holding.
module tb_shift_add_multiplier;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shift_add_multiplier_if #(.N(N)) bus ();

  shift_add_multiplier #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [2*N-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: interpret operands as integers and multiply; keep the low 2N bits.
  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic s);
    longint sa;
    longint sb;
    longint p;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[N-1]) sa = sa - (longint'(1) << N);
    if (s && b[N-1]) sb = sb - (longint'(1) << N);
    p = sa * sb;
    return p[2*N-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one comparison per completed output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.valid_o === 1'b1 && bus.ready_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", bus.product);
        end else begin
          check("product", bus.product, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // One transaction: wait for ready_i, present operands, measure latency, optionally stall
  // the consumer for 'hold' cycles, optionally scramble operands while busy.
  task automatic txn(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                     input int hold, input bit toggle, input bit keep_valid);
    int k;
    int lat;
    logic [2*N-1:0] held;
    k = 0;
    while (bus.ready_i !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check("ready_before_accept", bus.ready_i, 1);
    bus.a        = a;
    bus.b        = b;
    bus.signed_i = s;
    bus.valid_i  = 1'b1;
    exp_q.push_back(ref_mul(a, b, s));
    lat = (a == '0 || b == '0) ? 0 : N;
    tick();
    if (!keep_valid) bus.valid_i = 1'b0;
    k = 0;
    while (bus.valid_o !== 1'b1 && k < 3 * N) begin
      check("ready_low_busy", bus.ready_i, 0);
      if (toggle) begin
        bus.a        = N'($urandom);
        bus.b        = N'($urandom);
        bus.signed_i = 1'($urandom);
      end
      tick();
      k++;
    end
    check("latency", k, lat);
    held = bus.product;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", bus.valid_o, 1);
      check("hold_product", bus.product, held);
    end
    bus.ready_o = 1'b1;
    tick();
    bus.ready_o = 1'b0;
    check("exit_valid_low", bus.valid_o, 0);
    check("exit_ready_high", bus.ready_i, 1);
  endtask

  initial begin
    rst          = 1'b1;
    bus.valid_i  = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.signed_i = 1'b0;
    bus.ready_o  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_ready", bus.ready_i, 1);
    check("reset_valid", bus.valid_o, 0);
    check("reset_product", bus.product, 0);

    // Directed cases.
    txn(8'd200, 8'd250, 1'b0, 0, 1'b0, 1'b0);
    txn(8'hFD,  8'd5,   1'b1, 0, 1'b0, 1'b0);
    txn(8'h80,  8'h80,  1'b1, 0, 1'b0, 1'b0);
    txn(8'h80,  8'h7F,  1'b1, 5, 1'b0, 1'b0);
    txn(8'hFF,  8'hFF,  1'b0, 0, 1'b0, 1'b0);
    txn(8'hFF,  8'hFF,  1'b1, 0, 1'b0, 1'b0);
    txn(8'd0,   8'd77,  1'b0, 0, 1'b0, 1'b0);
    txn(8'h9C,  8'd0,   1'b1, 0, 1'b0, 1'b0);
    txn(8'd123, 8'd45,  1'b0, 2, 1'b1, 1'b0);
    txn(8'hC1,  8'h37,  1'b1, 0, 1'b1, 1'b0);
    // valid_i held high across DONE exit: next accept follows immediately.
    txn(8'd17,  8'd19,  1'b0, 1, 1'b0, 1'b1);
    txn(8'hF0,  8'd9,   1'b1, 0, 1'b0, 1'b0);

    // Reset during the 4th COMPUTING cycle discards the operation.
    bus.a        = 8'd200;
    bus.b        = 8'd250;
    bus.signed_i = 1'b0;
    bus.valid_i  = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset_ready", bus.ready_i, 1);
    check("midreset_valid", bus.valid_o, 0);
    check("midreset_product", bus.product, 0);
    bus.ready_o = 1'b1;
    for (int i = 0; i < 2 * N; i++) begin
      tick();
      check("midreset_no_output", bus.valid_o, 0);
    end
    bus.ready_o = 1'b0;
    txn(8'd3, 8'd7, 1'b0, 0, 1'b0, 1'b0);

    // Randomised cases, with occasional zero operands.
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      ra = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      txn(ra, rb, 1'($urandom), $urandom_range(0, 3), 1'($urandom), 1'b0);
    end

    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Parametrised sequential shift-and-add multiplier with a ready/valid handshake on both sides. It takes one operand pair per transaction and handles both unsigned and two's-complement signed operands, selected per transaction. Every non-zero operation takes a fixed N+1 cycles. It is the general-purpose multiply unit placed between a requesting datapath (upstream) and a consumer (downstream), replacing repeated-addition multiplication whose latency depended on operand value.

## Interface
- N, default 8, operand width in bits; legal range N >= 2.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  1  upstream asserts when a, b, signed_i are valid.
- ready_i  output  1  high when the block can accept an operand pair.
- a  input  N  multiplicand.
- b  input  N  multiplier.
- signed_i  input  1  1: a, b are two's-complement; 0: unsigned.
- valid_o  output  1  high when product is valid.
- ready_o  input  1  downstream accepts product when high.
- product  output  2N  result; two's-complement when the transaction was signed.

## Operation
- States: IDLE, COMPUTING, DONE. Unused encodings go to IDLE on the next edge.
- ready_i = (state == IDLE). valid_o = (state == DONE). Both are combinational from state only.
- Accept happens at a rising edge with state IDLE and valid_i=1. On accept, the block latches:
  - mag_a = |a| and mag_b = |b| as N-bit unsigned magnitudes. Negation applies only when signed_i=1 and the sign bit is set. -2^(N-1) maps to 2^(N-1), which fits in N bits.
  - neg = signed_i & a[N-1] & (a≠0) ^ (b[N-1] & b≠0), simplified to signed_i & (a[N-1] ^ b[N-1]).
  - accumulator = 0, counter = N.
- Zero shortcut: if a==0 or b==0 at accept, product <= 0 and the next state is DONE. COMPUTING is skipped.
- Otherwise the next state is COMPUTING. Each COMPUTING edge performs one step:
  - if the current LSB of the multiplier shift register is 1, add mag_a into the upper N+1 bits of the 2N+1-bit accumulator;
  - shift the accumulator right 1; shift the multiplier register right 1;
  - decrement counter.
- On the COMPUTING edge where counter==1:
  - the final step completes;
  - product <= neg ? -(result) : result, with result being the 2N-bit magnitude;
  - state -> DONE.
- DONE: product and valid_o are held stable. If ready_o=1, state -> IDLE at that edge. No accept occurs in the same cycle because ready_i=0 in DONE.
- a, b, signed_i and valid_i are ignored outside IDLE. Operands changing mid-computation have no effect.
- product holds its last value in IDLE until the next completion, but is meaningful only while valid_o=1.
- Width rules:
  - unsigned max (2^N-1)^2 fits in 2N bits;
  - signed (-2^(N-1))^2 = 2^(2N-2) fits as positive 2N-bit two's-complement;
  - the signed minimum product -2^(2N-2)+2^(N-1) fits.
  - There is no overflow case.

## Timing
- Reset values: state IDLE, ready_i=1, valid_o=0, product=0, counter=0, internal registers 0.
- rst has priority over all transitions. An assertion in any state, including mid-COMPUTING, discards the operation; the in-flight result is never presented.
- Latency, non-zero operands: accept at edge E0; valid_o rises after edge E0+N. N COMPUTING edges in total, so the product is visible N cycles after the accept cycle.
- Latency, zero shortcut: valid_o rises after edge E0 (visible 1 cycle after the accept cycle).
- Throughput: at most one transaction per N+2 cycles. The DONE->IDLE edge costs one cycle before the next accept.
- Backpressure: DONE persists indefinitely while ready_o=0. product must not change.
- Latency is independent of operand values except for the zero shortcut.

## Test plan
- Unsigned, N=8: a=200, b=250, signed_i=0 → product=0xC350 (50000). valid_o rises exactly 8 cycles after the accept cycle. ready_i is low throughout.
- Signed, N=8: a=0xFD (-3), b=5 → product=0xFFF1 (-15). Also a=0x80, b=0x80 → 0x4000, and a=0x80, b=0x7F → 0xC080 (-16256).
- Unsigned max: a=0xFF, b=0xFF, signed_i=0 → 0xFE01. The same operands with signed_i=1 → 0x0001.
- Zero shortcut: a=0, b=77 → product=0, valid_o high 1 cycle after accept. Then a=0x9C, b=0 with signed_i=1 → product=0 (not negative zero artefacts).
- Handshake:
  - hold ready_o=0 for 5 cycles in DONE → product stable and valid_o stays high;
  - toggle a/b during COMPUTING → result unaffected;
  - valid_i held high continuously → next accept occurs exactly one cycle after the DONE exit.
- Reset mid-operation: assert rst at the 4th COMPUTING cycle of 200×250 → next cycle state IDLE, ready_i=1, valid_o=0, product=0. A fresh 3×7 then returns 21.
